// File: rtl/dm_resp_if.sv
// Request/response bus between the MEM stage (master) and the data memory responder (slave).
interface dm_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        err;
    logic        busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, err, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, err, busy
    );
endinterface

// File: rtl/dm_resp.sv
// Data memory responder: accepts one load/store at a time, waits WAIT cycles, then answers
// with a single-cycle registered ack. Misaligned or out-of-range addresses answer with err.
module dm_resp #(
    parameter int unsigned WAIT = 2,   // wait states, 0..15
    parameter int unsigned AW   = 10   // word-address width
) (
    input  logic     clk,
    input  logic     clr,
    dm_resp_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    localparam int unsigned Depth = 1 << AW;

    state_e      state_q;
    logic [3:0]  cnt_q;

    // Request fields captured at acceptance
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    // Registered outputs
    logic        ack_q;
    logic        err_q;
    logic        busy_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [Depth];

    // Effective request for the edge that enters RESP
    logic          idle_take;
    logic          enter_resp;
    logic          src_we;
    logic [31:0]   src_addr;
    logic [31:0]   src_wdata;
    logic [3:0]    src_be;
    logic [AW-1:0] src_idx;
    logic          src_err;
    logic          mem_wr;

    // With WAIT=0 the response is produced on the acceptance edge, so the live bus is used;
    // otherwise the captured copy is used and later bus changes are ignored.
    always_comb begin
        idle_take  = (state_q == StIdle) && bus.req;
        enter_resp = (idle_take && (WAIT == 0)) || ((state_q == StWait) && (cnt_q == 4'd1));
        if (state_q == StIdle) begin
            src_we    = bus.we;
            src_addr  = bus.addr;
            src_wdata = bus.wdata;
            src_be    = bus.be;
        end else begin
            src_we    = we_q;
            src_addr  = addr_q;
            src_wdata = wdata_q;
            src_be    = be_q;
        end
        src_idx = src_addr[AW+1:2];
        src_err = (src_addr[1:0] != 2'b00) || ((src_addr >> (AW + 2)) != 32'd0);
        mem_wr  = enter_resp && src_we && !src_err;
    end

    // Storage: byte-enabled write on the edge entering RESP; never reset, and held off
    // while clr is low so an aborted transaction cannot write.
    always_ff @(posedge clk) begin
        if (mem_wr && clr) begin
            for (int i = 0; i < 4; i++) begin
                if (src_be[i]) begin
                    mem[src_idx][8*i +: 8] <= src_wdata[8*i +: 8];
                end
            end
        end
    end

    // Control FSM with wait counter, request capture and registered response outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        be_q    <= bus.be;
                        cnt_q   <= 4'(WAIT);
                        busy_q  <= 1'b1;
                        state_q <= (WAIT == 0) ? StResp : StWait;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                StWait: begin
                    cnt_q  <= cnt_q - 4'd1;
                    busy_q <= 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
            if (enter_resp) begin
                ack_q   <= 1'b1;
                err_q   <= src_err;
                rdata_q <= (!src_we && !src_err) ? mem[src_idx] : 32'd0;
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.busy  = busy_q;
    assign bus.rdata = rdata_q;

endmodule
